// File: rtl/xif_copro_pkg.sv
// Shared types for the coprocessor result path: instruction id width and the
// per-instruction tag that travels with each result.
package xif_copro_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
    } copro_tag_t;

endpackage

// File: rtl/xif_copro_result_fifo.sv
// Result buffer for the coprocessor writeback stage: DEPTH-entry FIFO with
// synchronous flush and an occupancy count.
module xif_copro_result_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  entry_t        wdata_i,
    output entry_t        rdata_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Flush wins over any push or pop in the same cycle.
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_i) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/xif_copro_wb_stage.sv
// Coprocessor writeback stage: buffers ex-stage results and presents them on the
// XIF result interface. Define XIF_COPRO_WB_BYPASS_EN for a same-cycle empty bypass.
module xif_copro_wb_stage
    import xif_copro_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter type         tag_t = xif_copro_pkg::copro_tag_t,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  tag_t                  tag_i,
    input  logic [XLEN-1:0]       result_i,
    input  logic                  flush_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic [CW-1:0]         count_o
);

    typedef struct packed {
        tag_t            tag;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t        wr_entry, head_entry, out_entry;
    logic [CW-1:0] count;
    logic          push, pop, out_valid;

    assign wr_entry   = '{tag: tag_i, data: result_i};
    assign in_ready_o = (count != CW'(DEPTH));

`ifdef XIF_COPRO_WB_BYPASS_EN
    logic bypass;
    assign bypass = (count == '0) & in_valid_i & ~flush_i;

    always_comb begin
        out_valid = (count != '0);
        out_entry = head_entry;
        push      = in_valid_i & in_ready_o;
        pop       = out_valid & result_ready_i;
        if (bypass) begin
            // Empty buffer: forward directly; store only if the core stalls.
            out_valid = 1'b1;
            out_entry = wr_entry;
            push      = ~result_ready_i;
            pop       = 1'b0;
        end
    end
`else
    always_comb begin
        out_valid = (count != '0);
        out_entry = head_entry;
        push      = in_valid_i & in_ready_o;
        pop       = out_valid & result_ready_i;
    end
`endif

    xif_copro_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .count_o (count)
    );

    // Result fields read as zero whenever nothing is being offered.
    always_comb begin
        result_valid_o = out_valid;
        result_id_o    = '0;
        result_rd_o    = '0;
        result_data_o  = '0;
        result_we_o    = 1'b0;
        if (out_valid) begin
            result_id_o   = out_entry.tag.id;
            result_rd_o   = out_entry.tag.rd;
            result_data_o = out_entry.data;
            result_we_o   = (out_entry.tag.rd != 5'd0);
        end
    end

    assign count_o = count;

endmodule

// File: tb/tb_xif_copro_wb_stage.sv
// Directed, table-driven bench for xif_copro_wb_stage (DEPTH=4, XLEN=64).
module tb_xif_copro_wb_stage;
    import xif_copro_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    copro_tag_t  tag_i = '0;
    logic [63:0] result_i = '0;
    logic        flush_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [63:0] result_data_o;
    logic [2:0]  count_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xif_copro_wb_stage #(
        .XLEN  (64),
        .DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .tag_i          (tag_i),
        .result_i       (result_i),
        .flush_i        (flush_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .result_data_o  (result_data_o),
        .count_o        (count_o)
    );

    typedef struct {
        logic        vld;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        flush;
        logic        rdy;
        logic        e_vld;
        logic [3:0]  e_id;
        logic [4:0]  e_rd;
        logic        e_we;
        logic [63:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_inrdy;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [3:0] id, input logic [4:0] rd,
                                input logic [63:0] data, input logic flush, input logic rdy,
                                input logic e_vld, input logic [3:0] e_id,
                                input logic [4:0] e_rd, input logic e_we,
                                input logic [63:0] e_data, input logic [2:0] e_cnt,
                                input logic e_inrdy);
        vec_t v;
        v = '{vld, id, rd, data, flush, rdy, e_vld, e_id, e_rd, e_we, e_data, e_cnt, e_inrdy};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_vld, input logic [3:0] e_id,
                            input logic [4:0] e_rd, input logic e_we, input logic [63:0] e_data,
                            input logic [2:0] e_cnt, input logic e_inrdy);
        chk({tag, " valid"}, 64'(result_valid_o), 64'(e_vld));
        chk({tag, " id"}, 64'(result_id_o), 64'(e_id));
        chk({tag, " rd"}, 64'(result_rd_o), 64'(e_rd));
        chk({tag, " we"}, 64'(result_we_o), 64'(e_we));
        chk({tag, " data"}, result_data_o, e_data);
        chk({tag, " count"}, 64'(count_o), 64'(e_cnt));
        chk({tag, " in_ready"}, 64'(in_ready_o), 64'(e_inrdy));
    endtask

    task automatic drive(input logic vld, input logic [3:0] id, input logic [4:0] rd,
                         input logic [63:0] data, input logic flush, input logic rdy);
        in_valid_i     = vld;
        tag_i.id       = id;
        tag_i.rd       = rd;
        result_i       = data;
        flush_i        = flush;
        result_ready_i = rdy;
    endtask

    vec_t vecs [23];

    initial begin
        // Each row: inputs driven this cycle, outputs expected before the next edge.
        vecs[0]  = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[1]  = mk(1, 3, 5, 64'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 0,            0, 1);
        vecs[2]  = mk(0, 0, 0, 0,            0, 1,  1, 3, 5, 1, 64'hDEAD_BEEF, 1, 1);
        vecs[3]  = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[4]  = mk(1, 1, 1, 64'h10,       0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[5]  = mk(1, 2, 2, 64'h11,       0, 0,  1, 1, 1, 1, 64'h10,       1, 1);
        vecs[6]  = mk(1, 3, 3, 64'h12,       0, 0,  1, 1, 1, 1, 64'h10,       2, 1);
        vecs[7]  = mk(1, 4, 4, 64'h13,       0, 0,  1, 1, 1, 1, 64'h10,       3, 1);
        vecs[8]  = mk(1, 5, 6, 64'h55,       0, 0,  1, 1, 1, 1, 64'h10,       4, 0);
        vecs[9]  = mk(1, 5, 6, 64'h55,       0, 1,  1, 1, 1, 1, 64'h10,       4, 0);
        vecs[10] = mk(0, 0, 0, 0,            0, 1,  1, 2, 2, 1, 64'h11,       3, 1);
        vecs[11] = mk(0, 0, 0, 0,            0, 1,  1, 3, 3, 1, 64'h12,       2, 1);
        vecs[12] = mk(0, 0, 0, 0,            0, 1,  1, 4, 4, 1, 64'h13,       1, 1);
        vecs[13] = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[14] = mk(1, 9, 0, 64'h1,        0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[15] = mk(0, 0, 0, 0,            0, 0,  1, 9, 0, 0, 64'h1,        1, 1);
        vecs[16] = mk(1, 10, 7, 64'h20,      0, 0,  1, 9, 0, 0, 64'h1,        1, 1);
        vecs[17] = mk(1, 11, 8, 64'h21,      0, 0,  1, 9, 0, 0, 64'h1,        2, 1);
        vecs[18] = mk(1, 12, 9, 64'h22,      1, 0,  1, 9, 0, 0, 64'h1,        3, 1);
        vecs[19] = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[20] = mk(1, 13, 10, 64'h30,     0, 0,  0, 0, 0, 0, 0,            0, 1);
        vecs[21] = mk(0, 0, 0, 0,            0, 1,  1, 13, 10, 1, 64'h30,     1, 1);
        vecs[22] = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0, 0,            0, 1);

        #2;
        chk_outs("in_reset", 0, 0, 0, 0, 0, 0, 1);
        #20 rst_ni = 1'b1;

`ifndef XIF_COPRO_WB_BYPASS_EN
        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #2 drive(vecs[i].vld, vecs[i].id, vecs[i].rd, vecs[i].data, vecs[i].flush,
                     vecs[i].rdy);
            #2 chk_outs($sformatf("row%0d", i), vecs[i].e_vld, vecs[i].e_id, vecs[i].e_rd,
                        vecs[i].e_we, vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_inrdy);
        end
`else
        // Empty + ready: forwarded the same cycle and never stored.
        @(posedge clk);
        #2 drive(1, 7, 3, 64'h77, 0, 1);
        #2 chk_outs("bypass_same_cycle", 1, 7, 3, 1, 64'h77, 0, 1);
        @(posedge clk);
        #2 drive(0, 0, 0, 0, 0, 1);
        #2 chk_outs("bypass_not_stored", 0, 0, 0, 0, 0, 0, 1);
        // Empty + stalled: forwarded and also stored, stays valid.
        @(posedge clk);
        #2 drive(1, 6, 2, 64'h66, 0, 0);
        #2 chk_outs("bypass_stall", 1, 6, 2, 1, 64'h66, 0, 1);
        @(posedge clk);
        #2 drive(0, 0, 0, 0, 0, 1);
        #2 chk_outs("bypass_stored", 1, 6, 2, 1, 64'h66, 1, 1);
        // Flush suppresses the bypass.
        @(posedge clk);
        #2 drive(1, 5, 4, 64'h55, 1, 1);
        #2 chk_outs("bypass_flush", 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2 drive(0, 0, 0, 0, 0, 0);
        #2 chk_outs("bypass_flush_after", 0, 0, 0, 0, 0, 0, 1);
`endif

        // Two entries buffered, then asynchronous reset mid-cycle.
        @(posedge clk);
        #2 drive(1, 2, 1, 64'hA1, 0, 0);
        @(posedge clk);
        #2 drive(1, 3, 2, 64'hA2, 0, 0);
        @(posedge clk);
        #2 drive(0, 0, 0, 0, 0, 0);
        #1 chk_outs("pre_reset", 1, 2, 1, 1, 64'hA1, 2, 1);
        rst_ni = 1'b0;
        #1 chk_outs("async_reset", 0, 0, 0, 0, 0, 0, 1);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #2 chk_outs("post_reset", 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
